// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random source with a rejection-sampling draw engine.
// A draw returns a value in [0, limit) (or full range for limit=0) with a bounded number of tries.
module lfsr_rng #(
   parameter int               WIDTH   = 16,
   parameter logic [WIDTH-1:0] TAPS    = 16'hD008,
   parameter logic [WIDTH-1:0] SEED    = '0,
   parameter int               MAX_TRY = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             req,
   input  logic [WIDTH-1:0] limit,
   input  logic             rnd_ready,
   output logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] rnd_out,
   output logic             rnd_valid,
   output logic             busy,
   output logic             lockup_err
);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} fsm_t;

   localparam logic [WIDTH-1:0] ONES      = '1;
   localparam logic [WIDTH-1:0] RST_STATE = (SEED == ONES) ? '0 : SEED;
   localparam logic             RST_LOCK  = (SEED == ONES);
   localparam logic [7:0]       LAST_TRY  = 8'(MAX_TRY - 1);

   fsm_t             fsm_reg, fsm_next;
   logic [WIDTH-1:0] state_reg, state_next;
   logic             lockup_reg, lockup_next;
   logic [7:0]       try_reg, try_next;
   logic [WIDTH-1:0] lim_reg, lim_next;
   logic [WIDTH-1:0] mask_reg, mask_next;
   logic [WIDTH-1:0] rnd_reg, rnd_next;

   logic [WIDTH-1:0] lim_dec;
   logic [WIDTH-1:0] req_mask;
   logic [WIDTH-1:0] stepped;
   logic [WIDTH-1:0] cand;
   logic             accept;
   logic [WIDTH-1:0] load_val;
   logic             do_load;

   // Smear limit-1 downward: bit i is set if any bit at or above i is set.
   // limit=0 wraps to all-ones, which naturally yields the full-range mask.
   assign lim_dec = limit - WIDTH'(1);
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
         assign req_mask[gi] = |lim_dec[WIDTH-1:gi];
      end
   endgenerate

   assign stepped = {state_reg[WIDTH-2:0], ~^(state_reg & TAPS)};
   assign cand    = state_reg & mask_reg;
   assign accept  = (lim_reg == '0) || (cand < lim_reg);

   always_comb begin
      fsm_next    = fsm_reg;
      state_next  = state_reg;
      lockup_next = lockup_reg;
      try_next    = try_reg;
      lim_next    = lim_reg;
      mask_next   = mask_reg;
      rnd_next    = rnd_reg;
      load_val    = stepped;
      do_load     = 1'b0;

      if (seed_load) begin
         load_val = seed_in;
         do_load  = 1'b1;
      end else if (fsm_reg == DRAW || en) begin
         do_load = 1'b1;
      end

      if (do_load) begin
         if (load_val == ONES) begin
            state_next  = '0;
            lockup_next = 1'b1;
         end else begin
            state_next = load_val;
         end
      end

      case (fsm_reg)
         IDLE: begin
            if (req) begin
               lim_next  = limit;
               mask_next = req_mask;
               try_next  = '0;
               fsm_next  = DRAW;
            end
         end
         DRAW: begin
            if (accept) begin
               rnd_next = cand;
               fsm_next = DONE;
            end else if (try_reg == LAST_TRY) begin
               // Halving a masked candidate always lands below the limit.
               rnd_next = cand >> 1;
               fsm_next = DONE;
            end else begin
               try_next = try_reg + 8'd1;
            end
         end
         DONE: begin
            if (rnd_ready) fsm_next = IDLE;
         end
         default: fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_reg    <= IDLE;
         state_reg  <= RST_STATE;
         lockup_reg <= RST_LOCK;
         try_reg    <= '0;
         lim_reg    <= '0;
         mask_reg   <= '0;
         rnd_reg    <= '0;
      end else begin
         fsm_reg    <= fsm_next;
         state_reg  <= state_next;
         lockup_reg <= lockup_next;
         try_reg    <= try_next;
         lim_reg    <= lim_next;
         mask_reg   <= mask_next;
         rnd_reg    <= rnd_next;
      end
   end

   assign state      = state_reg;
   assign rnd_out    = rnd_reg;
   assign rnd_valid  = (fsm_reg == DONE);
   assign busy       = (fsm_reg == DRAW) || (fsm_reg == DONE);
   assign lockup_err = lockup_reg;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: directed sequences plus randomized draws
// checked against a transaction-level reference model.
module tb_lfsr_rng;

   localparam int MAX_TRY = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       seed_load = 1'b0;
   logic [7:0] seed_in = '0;
   logic       req = 1'b0;
   logic [7:0] limit = '0;
   logic       rnd_ready = 1'b0;
   logic [7:0] state;
   logic [7:0] rnd_out;
   logic       rnd_valid;
   logic       busy;
   logic       lockup_err;

   int checks = 0;
   int failures = 0;

   logic [7:0] m_state;
   logic       m_lock;

   lfsr_rng #(
      .WIDTH(8), .TAPS(8'hC0), .SEED(8'h00), .MAX_TRY(MAX_TRY)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
      .req(req), .limit(limit), .rnd_ready(rnd_ready), .state(state),
      .rnd_out(rnd_out), .rnd_valid(rnd_valid), .busy(busy), .lockup_err(lockup_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference step: even number of tapped ones gives a feedback of 1.
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      int ones;
      ones = $countones(s & 8'hC0);
      return {s[6:0], ((ones % 2) == 0)};
   endfunction

   task automatic m_adv(input logic do_step);
      logic [7:0] n;
      if (do_step) begin
         n = lfsr_next(m_state);
         if (n == 8'hFF) begin
            m_state = 8'h00;
            m_lock  = 1'b1;
         end else begin
            m_state = n;
         end
      end
   endtask

   task automatic do_draw(input logic [7:0] lim, input int hold, input logic en_req);
      logic [7:0] mask, lim_m1, s, cand, exp_val, held;
      int         exp_cyc, cyc;
      logic       done;

      req = 1'b1; limit = lim; en = en_req;
      tick();
      m_adv(en_req);
      req = 1'b0; limit = 8'($urandom);
      check("busy_draw", busy, 1);

      // Smallest 2^k-1 not below limit-1 (limit-1 wraps to all-ones for limit 0).
      lim_m1 = lim - 8'd1;
      mask = 8'h00;
      while (mask < lim_m1) mask = (mask << 1) | 8'h01;

      s = m_state; done = 1'b0; exp_val = '0; exp_cyc = MAX_TRY;
      for (int t = 0; t < MAX_TRY; t++) begin
         if (!done) begin
            cand = s & mask;
            if (lim == 8'd0 || cand < lim) begin
               exp_val = cand; exp_cyc = t + 1; done = 1'b1;
            end else if (t == MAX_TRY - 1) begin
               exp_val = cand >> 1; exp_cyc = MAX_TRY; done = 1'b1;
            end
            s = lfsr_next(s);
         end
      end

      cyc = 0;
      do begin
         en = 1'($urandom);
         tick();
         cyc++;
         m_adv(1'b1);
      end while (!rnd_valid && cyc < MAX_TRY + 2);
      en = 1'b0;
      check("latency", 32'(cyc), 32'(exp_cyc));
      check("valid", rnd_valid, 1);
      check("rnd_out", rnd_out, exp_val);
      check("state_draw", state, m_state);
      held = rnd_out;

      for (int i = 0; i < hold; i++) begin
         en = 1'($urandom); req = 1'b1; limit = 8'($urandom);
         tick();
         m_adv(en);
         check("hold_valid", rnd_valid, 1);
         check("hold_out", rnd_out, held);
         check("hold_state", state, m_state);
      end

      req = 1'b0; rnd_ready = 1'b1; en = 1'($urandom);
      tick();
      m_adv(en);
      rnd_ready = 1'b0; en = 1'b0;
      check("ack_valid", rnd_valid, 0);
      check("ack_busy", busy, 0);
      check("ack_state", state, m_state);
      $display("draw lim=%0d mask=%0h val=%0d cycles=%0d state=%0h", lim, mask, exp_val, exp_cyc, m_state);
   endtask

   task automatic load_seed(input logic [7:0] v);
      seed_load = 1'b1; seed_in = v;
      tick();
      seed_load = 1'b0;
      if (v == 8'hFF) begin
         m_state = 8'h00; m_lock = 1'b1;
      end else begin
         m_state = v;
      end
   endtask

   logic [7:0] exp_seq [8];

   initial begin
      exp_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFE};
      m_state = 8'h00; m_lock = 1'b0;

      tick(); tick();
      check("rst_state", state, 8'h00);
      check("rst_valid", rnd_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out", rnd_out, 8'h00);
      check("rst_lock", lockup_err, 0);
      rst = 1'b1;
      $display("reset released");

      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         m_adv(1'b1);
         check("free_run", state, exp_seq[i]);
      end
      $display("free-run sequence done state=%0h", state);

      load_seed(8'hFF);
      check("lock_state", state, 8'h00);
      check("lock_flag", lockup_err, 1);
      load_seed(8'h5A);
      check("seed_wins", state, 8'h5A);
      for (int i = 0; i < 3; i++) begin
         tick();
         m_adv(1'b1);
      end
      check("lock_sticky", lockup_err, 1);
      check("state_after", state, m_state);
      en = 1'b0;
      $display("seed/lockup transaction done");

      rst = 1'b0;
      #1;
      check("rst_lock_clr", lockup_err, 0);
      check("rst_state2", state, 8'h00);
      tick();
      rst = 1'b1;
      m_state = 8'h00; m_lock = 1'b0;

      load_seed(8'h07);
      do_draw(8'd5, 0, 1'b0);
      do_draw(8'd0, 0, 1'b0);
      do_draw(8'd1, 0, 1'b1);
      do_draw(8'd200, 10, 1'b0);

      // Abort a draw that needs many tries.
      load_seed(8'h07);
      req = 1'b1; limit = 8'd5;
      tick();
      req = 1'b0;
      tick();
      check("abort_busy_pre", busy, 1);
      #2;
      rst = 1'b0;
      #1;
      check("abort_valid", rnd_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_state", state, 8'h00);
      tick();
      check("abort_valid2", rnd_valid, 0);
      rst = 1'b1;
      m_state = 8'h00; m_lock = 1'b0;
      $display("mid-draw reset abort done");

      for (int n = 0; n < 30; n++) begin
         int r;
         logic [7:0] lim;
         r = $urandom_range(0, 9);
         if (r == 0) lim = 8'd0;
         else if (r == 1) lim = 8'd1;
         else lim = 8'($urandom_range(2, 255));
         if ($urandom_range(0, 3) == 0) load_seed(8'($urandom));
         do_draw(lim, $urandom_range(0, 3), 1'($urandom));
      end
      check("final_lock", lockup_err, m_lock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
